// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and constants for the SPI slave front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_piso.sv
`default_nettype none
// ============================================================================
//  Module      : spi_piso
//  Description : Load/shift-out register driving MISO, MSB first, idles at 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_piso #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic         dout
);

    localparam int LW = $clog2(W);

    logic [W-1:0]  r_sreg;
    logic [LW-1:0] r_left;
    logic          r_out;

    // The MSB goes straight to the output on load so it appears the cycle after
    // the latch; r_left then counts the remaining bits still in r_sreg.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_sreg <= '0;
            r_left <= '0;
            r_out  <= 1'b0;
        end else if (load) begin
            r_sreg <= {din[W-2:0], 1'b0};
            r_left <= LW'(W - 1);
            r_out  <= din[W-1];
        end else if (r_left != '0) begin
            r_sreg <= {r_sreg[W-2:0], 1'b0};
            r_left <= r_left - 1'b1;
            r_out  <= r_sreg[W-1];
        end else begin
            r_out  <= 1'b0;
        end
    end

    assign dout = r_out;

endmodule
`default_nettype wire

// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_if
//  Description : SPI slave turning MOSI frames into RAM command words and
//                returning RAM read data on MISO.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_if #(
    parameter int FRAME_W = spi_pkg::FRAME_W,
    parameter int DATA_W  = spi_pkg::DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
);

    import spi_pkg::*;

    localparam int CW = $clog2(FRAME_W);
    localparam logic [CW-1:0] c_last_idx = CW'(FRAME_W - 2);

    spi_state_t         r_state;
    logic [CW-1:0]      r_cnt;
    logic [FRAME_W-2:0] r_shift;
    logic               r_done;
    logic               r_tx_taken;
    logic               r_rd_addr_seen;
    logic [FRAME_W-1:0] r_rx_data;
    logic               r_rx_valid;

    logic w_piso_load;
    logic w_piso_clear;

    // Read data is accepted once per frame, only after the read-data command went out.
    assign w_piso_load  = (r_state == READ_DATA) && r_done && !r_tx_taken && tx_valid && !SS_n;
    assign w_piso_clear = (r_state != READ_DATA) || SS_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_shift        <= '0;
            r_done         <= 1'b0;
            r_tx_taken     <= 1'b0;
            r_rd_addr_seen <= 1'b0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt      <= '0;
                    r_done     <= 1'b0;
                    r_tx_taken <= 1'b0;
                    if (!SS_n) begin
                        r_state <= CHK_CMD;
                    end
                end
                CHK_CMD: begin
                    if (SS_n) begin
                        r_state <= IDLE;
                    end else begin
                        r_shift <= {{(FRAME_W-2){1'b0}}, MOSI};
                        r_cnt   <= '0;
                        if (!MOSI) begin
                            r_state <= WRITE;
                        end else if (r_rd_addr_seen) begin
                            r_state <= READ_DATA;
                        end else begin
                            r_state <= READ_ADD;
                        end
                    end
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (SS_n) begin
                        r_state    <= IDLE;
                        r_cnt      <= '0;
                        r_done     <= 1'b0;
                        r_tx_taken <= 1'b0;
                    end else if (!r_done) begin
                        if (r_cnt == c_last_idx) begin
                            r_rx_data  <= {r_shift, MOSI};
                            r_rx_valid <= 1'b1;
                            r_done     <= 1'b1;
                            if (r_state == READ_ADD) begin
                                r_rd_addr_seen <= 1'b1;
                            end else if (r_state == READ_DATA) begin
                                r_rd_addr_seen <= 1'b0;
                            end
                        end else begin
                            r_shift <= {r_shift[FRAME_W-3:0], MOSI};
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end else if (w_piso_load) begin
                        r_tx_taken <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    spi_piso #(
        .W (DATA_W)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .clear (w_piso_clear),
        .load  (w_piso_load),
        .din   (tx_data),
        .dout  (MISO)
    );

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave_if
//  Description : Directed self-checking bench for spi_slave_if with an rx scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_if;

    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int n_rx     = 0;
    int n_pushed = 0;
    logic [9:0] sb[$];
    logic [9:0] last_rx;
    logic [9:0] exp_w;
    logic [7:0] pat;

    spi_slave_if #(
        .FRAME_W (FRAME_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [9:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            MOSI = w[i];
            tick();
        end
    endtask

    // Leaves the bench one step after the edge that samples bit 0.
    task automatic full_frame(input logic [9:0] w);
        sb.push_back(w);
        n_pushed++;
        SS_n = 1'b0;
        tick();
        shift_bits(w, 9, 0);
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick();
    endtask

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            n_rx++;
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_w = sb.pop_front();
                check("sb_rx_data", 32'(rx_data), 32'(exp_w));
                last_rx = exp_w;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_data = '0; tx_valid = 1'b0;
        last_rx = '0;
        repeat (3) tick();
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h000);
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_state", 32'(dut.r_state), 32'(IDLE));
        check("rst_seen", 32'(dut.r_rd_addr_seen), 32'd0);
        rst = 1'b0;
        tick();

        // Reset mid-frame after 5 bits
        SS_n = 1'b0;
        tick();
        shift_bits(10'h0F0, 9, 5);
        rst = 1'b1;
        tick();
        check("midrst_state", 32'(dut.r_state), 32'(IDLE));
        check("midrst_rx_valid", 32'(rx_valid), 32'd0);
        check("midrst_miso", 32'(MISO), 32'd0);
        rst = 1'b0; SS_n = 1'b1;
        tick();
        full_frame(10'h0F3);
        check("postrst_rx_valid", 32'(rx_valid), 32'd1);
        check("postrst_rx_data", 32'(rx_data), 32'h0F3);
        end_frame();

        // Write address: pulse exactly at the 11th edge after SS_n falls
        full_frame({OP_WR_ADDR, 8'h05});
        check("wa_rx_valid", 32'(rx_valid), 32'd1);
        check("wa_rx_data", 32'(rx_data), 32'h005);
        tick();
        check("wa_single_pulse", 32'(rx_valid), 32'd0);
        check("wa_seen", 32'(dut.r_rd_addr_seen), 32'd0);
        end_frame();

        // Write data, with trailing MOSI bits that must be ignored
        full_frame({OP_WR_DATA, 8'hAA});
        check("wd_rx_data", 32'(rx_data), 32'h1AA);
        MOSI = 1'b1;
        repeat (4) tick();
        check("wd_extra_bits", 32'(rx_valid), 32'd0);
        end_frame();
        check("wd_idle", 32'(dut.r_state), 32'(IDLE));

        // Read address then read data
        full_frame({OP_RD_ADDR, 8'h05});
        check("ra_rx_data", 32'(rx_data), 32'h205);
        tick();
        check("ra_seen", 32'(dut.r_rd_addr_seen), 32'd1);
        end_frame();
        full_frame({OP_RD_DATA, 8'hC7});
        check("rd_rx_valid", 32'(rx_valid), 32'd1);
        check("rd_miso_wait", 32'(MISO), 32'd0);
        tick();
        pat = 8'hAA;
        tx_data = pat; tx_valid = 1'b1;
        check("rd_seen_clr", 32'(dut.r_rd_addr_seen), 32'd0);
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rd_miso_bit%0d", 7 - i), 32'(MISO), 32'(pat[7 - i]));
            tick();
        end
        check("rd_miso_done", 32'(MISO), 32'd0);
        tx_valid = 1'b1; tx_data = 8'hFF;
        tick();
        check("rd_second_txv_ignored", 32'(MISO), 32'd0);
        tick();
        check("rd_second_txv_ignored2", 32'(MISO), 32'd0);
        tx_valid = 1'b0;
        end_frame();

        // Read cycle with SS_n rising mid-MISO shift
        full_frame({OP_RD_ADDR, 8'hA0});
        end_frame();
        full_frame({OP_RD_DATA, 8'hFF});
        tick();
        pat = 8'h3C;
        tx_data = pat; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rd2_miso_bit%0d", 7 - i), 32'(MISO), 32'(pat[7 - i]));
            tick();
        end
        end_frame();
        check("rd2_abort_miso", 32'(MISO), 32'd0);
        check("rd2_abort_state", 32'(dut.r_state), 32'(IDLE));

        // Abort a READ_ADD frame after 6 bits
        SS_n = 1'b0;
        tick();
        shift_bits(10'h255, 9, 4);
        end_frame();
        check("abort_state", 32'(dut.r_state), 32'(IDLE));
        check("abort_rx_valid", 32'(rx_valid), 32'd0);
        check("abort_rx_data", 32'(rx_data), 32'(last_rx));
        check("abort_seen", 32'(dut.r_rd_addr_seen), 32'd0);
        full_frame(10'h1E1);
        check("post_abort_rx_data", 32'(rx_data), 32'h1E1);
        end_frame();

        // Read command with no prior READ_ADD decodes as READ_ADD; tx_valid ignored
        tx_valid = 1'b1; tx_data = 8'hFF;
        sb.push_back(10'h2FF);
        n_pushed++;
        SS_n = 1'b0;
        tick();
        MOSI = 1'b1;
        tick();
        check("noaddr_state", 32'(dut.r_state), 32'(READ_ADD));
        shift_bits(10'h2FF, 8, 0);
        check("noaddr_rx_data", 32'(rx_data), 32'h2FF);
        for (int i = 0; i < 4; i++) begin
            check("noaddr_miso", 32'(MISO), 32'd0);
            tick();
        end
        check("noaddr_seen", 32'(dut.r_rd_addr_seen), 32'd1);
        tx_valid = 1'b0;
        end_frame();
        tick();

        check("rx_pulse_count", 32'(n_rx), 32'(n_pushed));
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
